// File: rtl/data_mem_responder_if.sv
// Load/store bus between the CPU datapath (master) and the data memory
// responder (slave). One request is held until its single-cycle ack.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store from the CPU, inserts
// WAIT_CYCLES wait states, then commits the store or returns the load word
// with a one-cycle ack. The word RAM is split into four byte lanes so that
// byte-enabled stores map onto plain byte-wide block RAM.
//
// Optional build macro: MEMRSP_ALIGN_CHECK_EN
//   defined   -> addr[1:0] != 0 at acceptance flags the transaction as
//                misaligned: no RAM write, rdata untouched, ack with err=1.
//   undefined -> addr[1:0] ignored, err always 0.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                ack_q;
    logic                busy_q;
    logic [31:0]         rdata_d;

    // The access edge is the last WAIT cycle; the RAM acts on it when the
    // transaction is allowed to touch memory.
    logic                access_d;

`ifdef MEMRSP_ALIGN_CHECK_EN
    logic                mis_d;
    logic                mis_q;
    logic                err_q;

    assign mis_d    = (bus.addr[1:0] != 2'b00);
    assign access_d = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !mis_q;
    assign bus.err  = err_q;

    // Misalignment flag is captured with the other request fields and
    // reported as a one-cycle err alongside ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == ST_IDLE && bus.req) begin
                mis_q <= mis_d;
            end
            if (state_q == ST_WAIT && cnt_q == 4'd0) begin
                err_q <= mis_q;
            end
        end
    end
`else
    logic                unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};
    assign access_d        = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign bus.err         = 1'b0;
`endif

    // Address bits above the RAM index alias onto the same words.
    logic                unused_addr_msb;
    assign unused_addr_msb = &{1'b0, bus.addr[31:ADDR_W+2]};

    // Control FSM: latch the request in IDLE, count wait states, then a
    // single RESP cycle carrying ack. busy covers WAIT and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        idx_q   <= bus.addr[ADDR_W+1:2];
                        wdata_q <= bus.wdata;
                        be_q    <= bus.be;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ack_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // One byte-wide RAM per lane; the lane's read register doubles as the
    // held rdata byte. Reset clears the read register and blocks the write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [0:DEPTH-1];
            logic [7:0] rd_q;

            // Byte lane access: write when enabled on a store, read on a load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= 8'h00;
                end else if (access_d) begin
                    if (we_q) begin
                        if (be_q[gi]) begin
                            ram[idx_q] <= wdata_q[8*gi +: 8];
                        end
                    end else begin
                        rd_q <= ram[idx_q];
                    end
                end
            end

            assign rdata_d[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_d;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a cycle-level transaction model (timestamps
// plus a word array) predicts ack/busy/err/rdata every cycle for the main
// instance; directed transactions pin the model with literal expectations.
// A second instance with WAIT_CYCLES=0 checks back-to-back acceptance.
module tb_data_mem_responder;
    localparam int W = 2;

    logic clk;
    logic rst;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [0:1023];
    bit          live = 0;
    int          m_cycle = 0;
    int          commit_at = 0;
    bit          m_busy = 0;
    bit          m_we;
    int          m_idx;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    bit          m_mis;
    bit          exp_ack = 0;
    bit          exp_busy = 0;
    bit          exp_err = 0;
    logic [31:0] exp_rdata = 32'h0;

    always @(posedge clk) begin
        m_cycle++;
        live = 1;
        if (rst) begin
            m_busy    = 0;
            exp_ack   = 0;
            exp_busy  = 0;
            exp_err   = 0;
            exp_rdata = 32'h0;
        end else begin
            exp_ack = 0;
            exp_err = 0;
            if (m_busy) begin
                if (m_cycle == commit_at) begin
                    exp_ack = 1;
                    exp_err = m_mis;
                    if (!m_mis) begin
                        if (m_we) begin
                            for (int i = 0; i < 4; i++)
                                if (m_be[i]) mem_m[m_idx][8*i +: 8] = m_wdata[8*i +: 8];
                        end else begin
                            exp_rdata = mem_m[m_idx];
                        end
                    end
                end else if (m_cycle == commit_at + 1) begin
                    m_busy   = 0;
                    exp_busy = 0;
                end
            end else if (bus.req) begin
                m_busy    = 1;
                exp_busy  = 1;
                m_we      = bus.we;
                m_idx     = int'((bus.addr >> 2) & 32'h3FF);
                m_wdata   = bus.wdata;
                m_be      = bus.be;
`ifdef MEMRSP_ALIGN_CHECK_EN
                m_mis     = (bus.addr[1:0] != 2'b00);
`else
                m_mis     = 0;
`endif
                // accept edge -> W+1 edges later the access edge opens RESP
                commit_at = m_cycle + W + 1;
            end
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("ack", {31'b0, bus.ack}, {31'b0, exp_ack});
            chk("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            chk("rdata", bus.rdata, exp_rdata);
            if (exp_ack) chk("err", {31'b0, bus.err}, {31'b0, exp_err});
        end
    end

    // ---------------- requester ----------------
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          bc;

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rdo, output logic ero,
                       output int lato, output int bco);
        bit got;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
        lato = 0; bco = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lato++;
            if (bus.busy) bco++;
            if (bus.ack) begin
                got = 1;
                break;
            end
            // fields are latched at acceptance; wiggling them must not matter
            bus.we = $urandom_range(0, 1) == 1;
            bus.addr = $urandom; bus.wdata = $urandom; bus.be = 4'($urandom);
        end
        rdo = bus.rdata;
        ero = bus.err;
        bus.req = 1'b0;
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL txn_timeout: no ack within 40 cycles for addr %h", a);
        end
        $display("txn we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
                 w, a, d, b, rdo, ero, lato);
    endtask

    logic [11:0] am, bm;
    int          acks;
    logic [31:0] ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.be = 0;
        bus0.req = 0; bus0.we = 0; bus0.addr = 0; bus0.wdata = 0; bus0.be = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, bus.ack}, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst0_ack", {31'b0, bus0.ack}, 32'h0);
        chk("rst0_busy", {31'b0, bus0.busy}, 32'h0);
        rst = 1'b0;

        // preload the word range used by random traffic
        for (int i = 0; i < 32; i++) txn(1, 32'(i * 4), $urandom, 4'hF, rd, er, lat, bc);

        // store/load with latency and busy width
        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, bc);
        chk("st_latency", 32'(lat), 32'd4);
        chk("st_busy_cycles", 32'(bc), 32'd4);
        txn(0, 32'h10, 32'h0, 4'h0, rd, er, lat, bc);
        chk("ld_deadbeef", rd, 32'hDEADBEEF);
        chk("ld_latency", 32'(lat), 32'd4);

        // reset mid-WAIT aborts a store to 0x40
        txn(1, 32'h40, 32'h0BADC0DE, 4'hF, rd, er, lat, bc);
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 32'h40; bus.wdata = 32'hCAFEF00D; bus.be = 4'hF;
        @(negedge clk);
        bus.req = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ack", {31'b0, bus.ack}, 32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_err", {31'b0, bus.err}, 32'h0);
        chk("abort_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        txn(0, 32'h40, 32'h0, 4'h0, rd, er, lat, bc);
        chk("abort_no_write", rd, 32'h0BADC0DE);

        // byte enables and be=0
        txn(1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, bc);
        txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, bc);
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, bc);
        chk("be_0101", rd, 32'h11BB33DD);
        txn(1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, bc);
        chk("be0_latency", 32'(lat), 32'd4);
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, bc);
        chk("be0_unchanged", rd, 32'h11BB33DD);

        // address wrap modulo depth
        txn(1, 32'h1000, 32'h5A5A5A5A, 4'hF, rd, er, lat, bc);
        txn(0, 32'h0000, 32'h0, 4'h0, rd, er, lat, bc);
        chk("wrap", rd, 32'h5A5A5A5A);

        // misaligned store
        txn(1, 32'h23, 32'h12345678, 4'hF, rd, er, lat, bc);
`ifdef MEMRSP_ALIGN_CHECK_EN
        chk("mis_err", {31'b0, er}, 32'h1);
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, bc);
        chk("mis_no_write", rd, 32'h11BB33DD);
        chk("aligned_err", {31'b0, er}, 32'h0);
`else
        chk("mis_err", {31'b0, er}, 32'h0);
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, bc);
        chk("mis_writes_word", rd, 32'h12345678);
`endif

        // back-to-back with req held, WAIT_CYCLES=0 instance
        @(negedge clk);
        bus0.req = 1; bus0.we = 1; bus0.addr = 32'h100; bus0.wdata = 32'h01020304; bus0.be = 4'hF;
        am = '0; bm = '0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            am[c] = bus0.ack;
            bm[c] = bus0.busy;
            if (c == 7) bus0.req = 0;
        end
        chk("b2b_ack_cycles", {20'b0, am}, 32'h124);
        chk("b2b_busy_cycles", {20'b0, bm}, 32'h1B6);

        // randomized traffic with occasional aborts
        for (int t = 0; t < 150; t++) begin
            ra = $urandom & 32'hFFFF_F07F;
            if ($urandom_range(0, 11) == 0) begin
                @(negedge clk);
                bus.req = 1; bus.we = $urandom_range(0, 1) == 1; bus.addr = ra;
                bus.wdata = $urandom; bus.be = 4'($urandom);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                bus.req = 0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                $display("abort addr=%h", ra);
            end else begin
                txn($urandom_range(0, 1) == 1, ra, $urandom, 4'($urandom), rd, er, lat, bc);
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
